// File: rtl/lcd_text_writer.sv
// Write-only HD44780 driver for the 2x16 character LCD on its 4-bit bus: power-on init,
// configuration, then frames built from a snapshot of the ALU's 32-character text buffer.
module lcd_text_writer #(
  parameter int T_POWERON = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_NIBGAP  = 50,
  parameter int CNT_W     = 20
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [255:0] iChars,
  input  logic         iUpdate,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [3:0]   SF_DATA,
  output logic         oBusy,
  output logic         oDone
);

  typedef enum logic [2:0] {S_POWERON, S_SETUP, S_EHIGH, S_GAP, S_WAIT, S_IDLE} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_CFG, PH_FRAME} phase_t;

  // Counter reload values: a state loaded with C_x lasts exactly T_x cycles.
  localparam logic [CNT_W-1:0] C_POWERON = CNT_W'(T_POWERON - 1);
  localparam logic [CNT_W-1:0] C_INIT1   = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] C_INIT2   = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] C_CMD     = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] C_CLEAR   = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] C_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_EHIGH   = CNT_W'(T_EHIGH - 1);
  localparam logic [CNT_W-1:0] C_GAP     = CNT_W'(T_NIBGAP - 1);
  localparam logic [5:0]       LAST_IDX  = 6'd33;

  state_t              r_state, w_state_nx;
  phase_t              r_phase, w_phase_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [5:0]          r_idx, w_idx_nx;
  logic                r_lo, w_lo_nx;
  logic                r_pend;
  logic [31:0][7:0]    r_chars;
  logic                w_snap, w_done, w_pend_clr, w_cnt_zero;
  logic [7:0]          w_byte;
  logic [4:0]          w_k;
  logic                w_rs_nx;
  logic [3:0]          w_nib_nx;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_nib_nx   = w_lo_nx ? w_byte[3:0] : w_byte[7:4];
  assign LCD_RW     = 1'b0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_POWERON;
      r_cnt   <= C_POWERON;
      r_phase <= PH_INIT;
      r_idx   <= '0;
      r_lo    <= 1'b0;
      r_pend  <= 1'b0;
      r_chars <= '0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      SF_DATA <= 4'h0;
      oBusy   <= 1'b1;
      oDone   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_phase <= w_phase_nx;
      r_idx   <= w_idx_nx;
      r_lo    <= w_lo_nx;
      r_pend  <= w_pend_clr ? 1'b0 : (r_pend | (iUpdate & (r_state != S_IDLE)));
      if (w_snap) r_chars <= iChars;
      // Bus only changes on entry to SETUP, so it is frozen whenever E can be high.
      if (w_state_nx == S_SETUP) begin
        LCD_RS  <= w_rs_nx;
        SF_DATA <= w_nib_nx;
      end
      LCD_E   <= (w_state_nx == S_EHIGH);
      oBusy   <= (w_state_nx != S_IDLE);
      oDone   <= w_done;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_idx_nx   = r_idx;
    w_lo_nx    = r_lo;
    w_cnt_nx   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_snap     = 1'b0;
    w_done     = 1'b0;
    w_pend_clr = 1'b0;
    case (r_state)
      S_POWERON: if (w_cnt_zero) begin
        w_state_nx = S_SETUP;
        w_cnt_nx   = C_SETUP;
      end
      S_SETUP: if (w_cnt_zero) begin
        w_state_nx = S_EHIGH;
        w_cnt_nx   = C_EHIGH;
      end
      S_EHIGH: if (w_cnt_zero) begin
        if (r_phase == PH_INIT) begin
          w_state_nx = S_WAIT;
          case (r_idx[1:0])
            2'd0:    w_cnt_nx = C_INIT1;
            2'd1:    w_cnt_nx = C_INIT2;
            default: w_cnt_nx = C_CMD;
          endcase
        end else if (!r_lo) begin
          w_state_nx = S_GAP;
          w_cnt_nx   = C_GAP;
        end else begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = (r_phase == PH_CFG && r_idx == 6'd3) ? C_CLEAR : C_CMD;
        end
      end
      S_GAP: if (w_cnt_zero) begin
        w_state_nx = S_SETUP;
        w_cnt_nx   = C_SETUP;
        w_lo_nx    = 1'b1;
      end
      S_WAIT: if (w_cnt_zero) begin
        w_state_nx = S_SETUP;
        w_cnt_nx   = C_SETUP;
        w_lo_nx    = 1'b0;
        w_idx_nx   = r_idx + 1'b1;
        case (r_phase)
          PH_INIT: if (r_idx == 6'd3) begin
            w_phase_nx = PH_CFG;
            w_idx_nx   = '0;
          end
          PH_CFG: if (r_idx == 6'd3) begin
            w_phase_nx = PH_FRAME;
            w_idx_nx   = '0;
            w_snap     = 1'b1;
          end
          default: if (r_idx == LAST_IDX) begin
            w_done   = 1'b1;
            w_idx_nx = '0;
            // A request seen during the frame (or right now) restarts back-to-back.
            if (r_pend | iUpdate) begin
              w_snap     = 1'b1;
              w_pend_clr = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
              w_cnt_nx   = '0;
            end
          end
        endcase
      end
      S_IDLE: if (iUpdate) begin
        w_state_nx = S_SETUP;
        w_cnt_nx   = C_SETUP;
        w_phase_nx = PH_FRAME;
        w_idx_nx   = '0;
        w_lo_nx    = 1'b0;
        w_snap     = 1'b1;
      end
      default: w_state_nx = S_POWERON;
    endcase
  end

  // Byte (and RS) for the step about to be sent; init nibbles use a doubled byte so
  // the high nibble is the one sent.
  always_comb begin
    w_byte  = 8'h00;
    w_rs_nx = 1'b0;
    w_k     = '0;
    case (w_phase_nx)
      PH_INIT: w_byte = (w_idx_nx == 6'd3) ? 8'h22 : 8'h33;
      PH_CFG: begin
        case (w_idx_nx[1:0])
          2'd0:    w_byte = 8'h28;
          2'd1:    w_byte = 8'h06;
          2'd2:    w_byte = 8'h0C;
          default: w_byte = 8'h01;
        endcase
      end
      default: begin
        if (w_idx_nx == 6'd0) begin
          w_byte = 8'h80;
        end else if (w_idx_nx == 6'd17) begin
          w_byte = 8'hC0;
        end else begin
          w_rs_nx = 1'b1;
          w_k     = (w_idx_nx < 6'd17) ? 5'(w_idx_nx - 6'd1) : 5'(w_idx_nx - 6'd2);
          w_byte  = r_chars[5'd31 - w_k];
        end
      end
    endcase
  end

endmodule
